// File: rtl/mar_ctrl.sv
// mar_ctrl
//   Memory address register with multi-source load, increment and a
//   req/ack memory access sequencer with an optional timeout. The address
//   handed to memory is captured when an access starts and held stable
//   until the access completes or is aborted.
//
// Parameters
//   AW        address width in bits
//   NSRC      number of load sources (>=1), higher index wins
//   AUTO_INC  1: register increments when an access is acknowledged
//   TIMEOUT   cycles allowed in REQ without ack before abort, 0 = no limit
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous reset, active-low
//   ld_sel     per-source load request (may be multi-hot)
//   src_addr   flattened sources, source i = [i*AW +: AW]
//   inc        increment register by 1 (IDLE only)
//   mem_start  request a memory access (IDLE only)
//   mem_ack    memory acknowledge (REQ only)
//   mar_out    current register value
//   mem_addr   address presented to memory
//   mem_req    registered access request
//   busy       high while an access is outstanding
//   err        sticky timeout flag, cleared by the next accepted access
//   wrap       one-cycle pulse when an increment rolls over all-ones -> 0
module mar_ctrl #(
   parameter int AW       = 8,
   parameter int NSRC     = 2,
   parameter int AUTO_INC = 0,
   parameter int TIMEOUT  = 15
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NSRC-1:0]      ld_sel,
   input  logic [NSRC*AW-1:0]   src_addr,
   input  logic                 inc,
   input  logic                 mem_start,
   input  logic                 mem_ack,
   output logic [AW-1:0]        mar_out,
   output logic [AW-1:0]        mem_addr,
   output logic                 mem_req,
   output logic                 busy,
   output logic                 err,
   output logic                 wrap
);

   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic {
      IDLE,
      REQ
   } state_t;

   state_t          r_state;
   logic [AW-1:0]   r_mar;
   logic [AW-1:0]   r_memAddr;
   logic            r_memReq;
   logic            r_busy;
   logic            r_err;
   logic            r_wrap;
   logic [TW-1:0]   r_timer;

   logic [AW-1:0]   w_ldAddr;
   logic            w_ldAny;
   logic [AW-1:0]   w_marInc;
   logic            w_marOnes;
   logic [AW-1:0]   w_idleNext;
   logic            w_idleWrap;
   logic [TW-1:0]   w_timerNext;
   logic            w_timeout;

   // Scanning upward lets the highest set source overwrite lower ones.
   always_comb begin
      w_ldAddr = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (ld_sel[i]) begin
            w_ldAddr = src_addr[i*AW +: AW];
         end
      end
   end

   assign w_ldAny     = |ld_sel;
   assign w_marInc    = r_mar + AW'(1);
   assign w_marOnes   = &r_mar;
   assign w_idleNext  = w_ldAny ? w_ldAddr : (inc ? w_marInc : r_mar);
   assign w_idleWrap  = !w_ldAny && inc && w_marOnes;
   assign w_timerNext = r_timer + TW'(1);
   // Expires on the edge that completes the TIMEOUT-th cycle spent in REQ.
   assign w_timeout   = (TIMEOUT > 0) && (w_timerNext == TW'(TIMEOUT));

   // Sequencer. The IDLE next-address is also what gets latched into
   // mem_addr on start, so a same-cycle load/inc is forwarded to memory.
   // In REQ an ack takes precedence over a timeout expiring on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_mar     <= '0;
         r_memAddr <= '0;
         r_memReq  <= 1'b0;
         r_busy    <= 1'b0;
         r_err     <= 1'b0;
         r_wrap    <= 1'b0;
         r_timer   <= '0;
      end else begin
         r_wrap <= 1'b0;
         case (r_state)
            IDLE: begin
               r_mar  <= w_idleNext;
               r_wrap <= w_idleWrap;
               if (mem_start) begin
                  r_state   <= REQ;
                  r_memReq  <= 1'b1;
                  r_busy    <= 1'b1;
                  r_timer   <= '0;
                  r_err     <= 1'b0;
                  r_memAddr <= w_idleNext;
               end
            end
            REQ: begin
               if (mem_ack) begin
                  r_state  <= IDLE;
                  r_memReq <= 1'b0;
                  r_busy   <= 1'b0;
                  if (AUTO_INC != 0) begin
                     r_mar  <= w_marInc;
                     r_wrap <= w_marOnes;
                  end
               end else if (TIMEOUT > 0) begin
                  if (w_timeout) begin
                     r_state  <= IDLE;
                     r_memReq <= 1'b0;
                     r_busy   <= 1'b0;
                     r_err    <= 1'b1;
                  end else begin
                     r_timer <= w_timerNext;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign mar_out  = r_mar;
   assign mem_addr = r_memAddr;
   assign mem_req  = r_memReq;
   assign busy     = r_busy;
   assign err      = r_err;
   assign wrap     = r_wrap;

endmodule

// File: tb/tb_mar_ctrl.sv
// tb_mar_ctrl
//   Directed self-checking bench for mar_ctrl built with AW=8, NSRC=2,
//   AUTO_INC=1, TIMEOUT=4. Inputs change 1 time unit after each rising
//   edge and outputs are checked there, away from the active edge.
module tb_mar_ctrl;

   logic        clk;
   logic        rst_n;
   logic [1:0]  ld_sel;
   logic [15:0] src_addr;
   logic        inc;
   logic        mem_start;
   logic        mem_ack;
   logic [7:0]  mar_out;
   logic [7:0]  mem_addr;
   logic        mem_req;
   logic        busy;
   logic        err;
   logic        wrap;

   int nVectors = 0;
   int nMiss    = 0;

   mar_ctrl #(
      .AW       (8),
      .NSRC     (2),
      .AUTO_INC (1),
      .TIMEOUT  (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ld_sel    (ld_sel),
      .src_addr  (src_addr),
      .inc       (inc),
      .mem_start (mem_start),
      .mem_ack   (mem_ack),
      .mar_out   (mar_out),
      .mem_addr  (mem_addr),
      .mem_req   (mem_req),
      .busy      (busy),
      .err       (err),
      .wrap      (wrap)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One clock step: inputs already set, wait past the edge before checking.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   // Single comparison point with an immediate assertion.
   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      nVectors++;
      assert (observed === expected)
      else begin
         nMiss++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      ld_sel    = 2'b00;
      src_addr  = 16'h0000;
      inc       = 1'b0;
      mem_start = 1'b0;
      mem_ack   = 1'b0;

      // Reset state before any clock edge.
      #3;
      checkOutput("rst_mar",   16'(mar_out),  16'h00);
      checkOutput("rst_addr",  16'(mem_addr), 16'h00);
      checkOutput("rst_req",   16'(mem_req),  16'h0);
      checkOutput("rst_busy",  16'(busy),     16'h0);
      checkOutput("rst_err",   16'(err),      16'h0);
      checkOutput("rst_wrap",  16'(wrap),     16'h0);
      rst_n = 1'b1;
      applyStimulus();

      // Multi-hot load: source 1 wins, inc ignored.
      src_addr = {8'h34, 8'h12};
      ld_sel   = 2'b11;
      inc      = 1'b1;
      applyStimulus();
      checkOutput("ld_prio_mar",  16'(mar_out), 16'h34);
      checkOutput("ld_prio_wrap", 16'(wrap),    16'h0);

      // Single-source load from source 0.
      src_addr = {8'h00, 8'hFF};
      ld_sel   = 2'b01;
      inc      = 1'b0;
      applyStimulus();
      checkOutput("ld0_mar", 16'(mar_out), 16'hFF);

      // Increment wraps 0xFF -> 0x00 with a single wrap pulse.
      ld_sel = 2'b00;
      inc    = 1'b1;
      applyStimulus();
      checkOutput("wrap_mar",  16'(mar_out), 16'h00);
      checkOutput("wrap_flag", 16'(wrap),    16'h1);
      applyStimulus();
      checkOutput("inc2_mar",  16'(mar_out), 16'h01);
      checkOutput("inc2_wrap", 16'(wrap),    16'h0);
      inc = 1'b0;
      applyStimulus();
      checkOutput("hold_mar",  16'(mar_out), 16'h01);

      // Ack while idle is ignored.
      mem_ack = 1'b1;
      applyStimulus();
      checkOutput("idle_ack_mar", 16'(mar_out), 16'h01);
      checkOutput("idle_ack_req", 16'(mem_req), 16'h0);
      mem_ack = 1'b0;

      // Load 0x40, then start with a forwarded load of 0x55.
      src_addr = {8'h00, 8'h40};
      ld_sel   = 2'b01;
      applyStimulus();
      checkOutput("ld40_mar", 16'(mar_out), 16'h40);
      src_addr  = {8'h00, 8'h55};
      mem_start = 1'b1;
      applyStimulus();
      checkOutput("fwd_addr", 16'(mem_addr), 16'h55);
      checkOutput("fwd_req",  16'(mem_req),  16'h1);
      checkOutput("fwd_busy", 16'(busy),     16'h1);
      checkOutput("fwd_mar",  16'(mar_out),  16'h55);

      // Load and inc during REQ are ignored.
      mem_start = 1'b0;
      ld_sel    = 2'b10;
      src_addr  = {8'h99, 8'h00};
      inc       = 1'b1;
      applyStimulus();
      checkOutput("req_ign_mar",  16'(mar_out),  16'h55);
      checkOutput("req_ign_addr", 16'(mem_addr), 16'h55);
      checkOutput("req_ign_req",  16'(mem_req),  16'h1);
      ld_sel = 2'b00;
      inc    = 1'b0;
      applyStimulus();
      checkOutput("req_c2_req", 16'(mem_req), 16'h1);

      // Ack on the third REQ cycle completes with auto-increment.
      mem_ack = 1'b1;
      applyStimulus();
      checkOutput("ack_req",  16'(mem_req),  16'h0);
      checkOutput("ack_busy", 16'(busy),     16'h0);
      checkOutput("ack_mar",  16'(mar_out),  16'h56);
      checkOutput("ack_addr", 16'(mem_addr), 16'h55);
      checkOutput("ack_err",  16'(err),      16'h0);
      mem_ack = 1'b0;

      // Timeout: no ack, mem_req high for exactly 4 cycles, then err.
      mem_start = 1'b1;
      applyStimulus();
      checkOutput("to_start_req", 16'(mem_req), 16'h1);
      mem_start = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         applyStimulus();
         checkOutput($sformatf("to_req_c%0d", c), 16'(mem_req), 16'h1);
      end
      applyStimulus();
      checkOutput("to_req",  16'(mem_req), 16'h0);
      checkOutput("to_busy", 16'(busy),    16'h0);
      checkOutput("to_err",  16'(err),     16'h1);
      checkOutput("to_mar",  16'(mar_out), 16'h56);
      applyStimulus();
      checkOutput("to_err_sticky", 16'(err), 16'h1);

      // Next start clears err; ack on the 4th cycle beats the timeout.
      mem_start = 1'b1;
      applyStimulus();
      checkOutput("clr_err", 16'(err),     16'h0);
      checkOutput("clr_req", 16'(mem_req), 16'h1);
      mem_start = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         applyStimulus();
         checkOutput($sformatf("race_req_c%0d", c), 16'(mem_req), 16'h1);
      end
      mem_ack = 1'b1;
      applyStimulus();
      checkOutput("race_req", 16'(mem_req), 16'h0);
      checkOutput("race_err", 16'(err),     16'h0);
      checkOutput("race_mar", 16'(mar_out), 16'h57);
      mem_ack = 1'b0;

      // Minimum 1-cycle access; auto-increment wraps 0xFF -> 0x00.
      src_addr  = {8'h00, 8'hFF};
      ld_sel    = 2'b01;
      mem_start = 1'b1;
      applyStimulus();
      checkOutput("min_addr", 16'(mem_addr), 16'hFF);
      checkOutput("min_req",  16'(mem_req),  16'h1);
      ld_sel    = 2'b00;
      mem_start = 1'b0;
      mem_ack   = 1'b1;
      applyStimulus();
      checkOutput("min_ack_req",  16'(mem_req), 16'h0);
      checkOutput("min_ack_mar",  16'(mar_out), 16'h00);
      checkOutput("min_ack_wrap", 16'(wrap),    16'h1);
      mem_ack = 1'b0;
      applyStimulus();
      checkOutput("min_wrap_off", 16'(wrap), 16'h0);

      // Start with a forwarded inc, then reset mid-REQ between edges.
      inc       = 1'b1;
      mem_start = 1'b1;
      applyStimulus();
      checkOutput("fwd_inc_addr", 16'(mem_addr), 16'h01);
      checkOutput("fwd_inc_req",  16'(mem_req),  16'h1);
      inc       = 1'b0;
      mem_start = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_req",  16'(mem_req),  16'h0);
      checkOutput("async_rst_busy", 16'(busy),     16'h0);
      checkOutput("async_rst_mar",  16'(mar_out),  16'h00);
      checkOutput("async_rst_addr", 16'(mem_addr), 16'h00);
      checkOutput("async_rst_err",  16'(err),      16'h0);
      rst_n = 1'b1;
      applyStimulus();
      checkOutput("post_rst_req", 16'(mem_req), 16'h0);

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
      $finish;
   end

endmodule
